fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_skid.sv | 49 ++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, bubble encoding and instruction field helpers for the fetch stage
package fetch_stage_pkg;

  localparam int ISIZE = 16;
  localparam int RSIZE = 4;
  localparam int ASIZE = 16;

  localparam logic [ISIZE-1:0] NOP      = 16'h4000;
  localparam logic [ASIZE-1:0] RESET_PC = 16'h0000;
  localparam logic [3:0]       OP_SHIFT = NOP[ISIZE-1:ISIZE-4];

  typedef struct packed {
    logic [3:0]       opcode;
    logic [RSIZE-1:0] rd;
    logic [RSIZE-1:0] rs;
    logic [RSIZE-1:0] rt;
  } instr_t;

  // Cond shares the upper three bits of the Rd field
  function automatic logic [2:0] instr_cond(input logic [ISIZE-1:0] instr);
    return instr[11:9];
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding register for the word returned by imem while the stage is stalled
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             flush,
  input  logic [ISIZE-1:0] in_data,
  input  logic [ASIZE-1:0] in_pc,
  output logic             out_valid,
  output logic [ISIZE-1:0] out_data,
  output logic [ASIZE-1:0] out_pc
);

  logic             valid_q, valid_d;
  logic [ISIZE-1:0] data_q, data_d;
  logic [ASIZE-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      data_d  = in_data;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= NOP;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, synchronous imem fetch, IF/ID register with skid, redirect squash and history
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  output logic [ASIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  output logic [ISIZE-1:0] Instr,
  output logic             InstrValid,
  output logic [ASIZE-1:0] PcId,
  output logic [ASIZE-1:0] PcIdPlus1,
  output logic [3:0]       OpCode,
  output logic [2:0]       Cond,
  output logic [RSIZE-1:0] AddrRd,
  output logic [RSIZE-1:0] AddrRs,
  output logic [RSIZE-1:0] AddrRt,
  output logic [ISIZE-1:0] LastInstr,
  output logic [ISIZE-1:0] Last2Instr
);

  logic [ASIZE-1:0] pc_f_q, pc_f_d;
  logic [ASIZE-1:0] pc_r_q, pc_r_d;
  logic             rvalid_q, rvalid_d;
  logic [ISIZE-1:0] id_q, id_d;
  logic [ASIZE-1:0] id_pc_q, id_pc_d;
  logic             id_v_q, id_v_d;
  logic [ISIZE-1:0] last1_q, last1_d;
  logic [ISIZE-1:0] last2_q, last2_d;

  logic             skid_v;
  logic [ISIZE-1:0] skid_data;
  logic [ASIZE-1:0] skid_pc;
  logic             skid_capture, skid_flush;
  logic             src_v;
  logic [ISIZE-1:0] src_data;
  logic [ASIZE-1:0] src_pc;
  instr_t           id_fields;

  // Only the first in-flight word of a stall is kept; re-reads of the held PC are dropped
  assign skid_capture = stall && !redirect && !skid_v && rvalid_q;
  assign skid_flush   = redirect || !stall;

  fetch_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (skid_capture),
    .flush     (skid_flush),
    .in_data   (imem_rdata),
    .in_pc     (pc_r_q),
    .out_valid (skid_v),
    .out_data  (skid_data),
    .out_pc    (skid_pc)
  );

  assign src_v    = skid_v || rvalid_q;
  assign src_data = skid_v ? skid_data : imem_rdata;
  assign src_pc   = skid_v ? skid_pc : pc_r_q;

  always_comb begin
    pc_f_d   = pc_f_q;
    pc_r_d   = pc_r_q;
    rvalid_d = rvalid_q;
    id_d     = id_q;
    id_pc_d  = id_pc_q;
    id_v_d   = id_v_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    if (redirect) begin
      pc_f_d   = redirect_pc;
      rvalid_d = 1'b0;
      id_d     = NOP;
      id_v_d   = 1'b0;
      last2_d  = last1_q;
      last1_d  = id_q;
    end else if (stall) begin
      rvalid_d = 1'b0;
    end else begin
      id_d     = src_v ? src_data : NOP;
      id_v_d   = src_v;
      id_pc_d  = src_pc;
      last2_d  = last1_q;
      last1_d  = id_q;
      pc_f_d   = pc_f_q + 1'b1;
      pc_r_d   = pc_f_q;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f_q   <= RESET_PC;
      pc_r_q   <= RESET_PC;
      rvalid_q <= 1'b0;
      id_q     <= NOP;
      id_pc_q  <= '0;
      id_v_q   <= 1'b0;
      last1_q  <= NOP;
      last2_q  <= NOP;
    end else begin
      pc_f_q   <= pc_f_d;
      pc_r_q   <= pc_r_d;
      rvalid_q <= rvalid_d;
      id_q     <= id_d;
      id_pc_q  <= id_pc_d;
      id_v_q   <= id_v_d;
      last1_q  <= last1_d;
      last2_q  <= last2_d;
    end
  end

  assign id_fields  = id_q;
  assign imem_addr  = pc_f_q;
  assign Instr      = id_q;
  assign InstrValid = id_v_q;
  assign PcId       = id_pc_q;
  assign PcIdPlus1  = id_pc_q + 1'b1;
  assign OpCode     = id_fields.opcode;
  assign Cond       = instr_cond(id_q);
  assign AddrRd     = id_fields.rd;
  assign AddrRs     = id_fields.rs;
  assign AddrRt     = id_fields.rt;
  assign LastInstr  = last1_q;
  assign Last2Instr = last2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a word-stream reference model
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [15:0] PcId;
  logic [15:0] PcIdPlus1;
  logic [3:0]  OpCode;
  logic [2:0]  Cond;
  logic [3:0]  AddrRd;
  logic [3:0]  AddrRs;
  logic [3:0]  AddrRt;
  logic [15:0] LastInstr;
  logic [15:0] Last2Instr;

  localparam logic [15:0] T_NOP = 16'h4000;
  localparam logic [15:0] T_RESET_PC = 16'h0000;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .InstrValid  (InstrValid),
    .PcId        (PcId),
    .PcIdPlus1   (PcIdPlus1),
    .OpCode      (OpCode),
    .Cond        (Cond),
    .AddrRd      (AddrRd),
    .AddrRs      (AddrRs),
    .AddrRt      (AddrRt),
    .LastInstr   (LastInstr),
    .Last2Instr  (Last2Instr)
  );

  logic [15:0] mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int errors = 0;
  int checks = 0;

  // Reference model: the stage delivers the stream mem[next], mem[next+1], ...
  // after a number of bubbles; stall freezes everything, redirect restarts the stream.
  logic [15:0] m_instr, m_pc, m_last1, m_last2, m_next;
  logic        m_valid;
  int          m_bub;

  task automatic model_reset();
    m_instr = T_NOP;
    m_valid = 1'b0;
    m_pc    = 16'h0000;
    m_last1 = T_NOP;
    m_last2 = T_NOP;
    m_next  = T_RESET_PC;
    m_bub   = 1;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [15:0] rp);
    if (r) begin
      m_last2 = m_last1;
      m_last1 = m_instr;
      m_instr = T_NOP;
      m_valid = 1'b0;
      m_next  = rp;
      m_bub   = 1;
    end else if (!s) begin
      m_last2 = m_last1;
      m_last1 = m_instr;
      if (m_bub > 0) begin
        m_instr = T_NOP;
        m_valid = 1'b0;
        m_bub   = m_bub - 1;
      end else begin
        m_instr = mem[m_next];
        m_valid = 1'b1;
        m_pc    = m_next;
        m_next  = m_next + 16'h0001;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("instr", Instr, m_instr);
    chk("valid", {15'd0, InstrValid}, {15'd0, m_valid});
    chk("last1", LastInstr, m_last1);
    chk("last2", Last2Instr, m_last2);
    chk("opcode", {12'd0, OpCode}, {12'd0, m_instr[15:12]});
    chk("cond", {13'd0, Cond}, {13'd0, m_instr[11:9]});
    chk("rd", {12'd0, AddrRd}, {12'd0, m_instr[11:8]});
    chk("rs", {12'd0, AddrRs}, {12'd0, m_instr[7:4]});
    chk("rt", {12'd0, AddrRt}, {12'd0, m_instr[3:0]});
    if (m_valid) begin
      chk("pcid", PcId, m_pc);
      chk("pcid_plus1", PcIdPlus1, m_pc + 16'h0001);
    end
  endtask

  task automatic cycle(input logic s, input logic r, input logic [15:0] rp, input logic rn);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    rst_n       = rn;
    @(posedge clk);
    if (!rn) model_reset();
    else model_step(s, r, rp);
    #1;
    check_all();
    if (!rn) begin
      chk("reset_imem_addr", imem_addr, T_RESET_PC);
      chk("reset_pcid", PcId, 16'h0000);
    end
  endtask

  task automatic run_until(input string name, input logic [15:0] target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (Instr === target) break;
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    end
    chk(name, Instr, target);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
    imem_rdata  = 16'h0000;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    rst_n       = 1'b0;
    model_reset();

    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);

    // free-run: NOP, NOP, 1000, 1001, ...
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    run_until("reach_1004", 16'h1004, 10);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // redirect to 0x40 while 1003 sits in ID
    cycle(1'b0, 1'b1, 16'h0000, 1'b1);
    run_until("reach_1003", 16'h1003, 10);
    cycle(1'b0, 1'b1, 16'h0040, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // redirect with simultaneous stall
    cycle(1'b1, 1'b1, 16'h0080, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // reset mid-stall with the skid full
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // PC wrap
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // random phase with random memory contents, loaded while in reset
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 600; i++) begin
      logic s, r, rn;
      logic [15:0] rp;
      s  = ($urandom_range(0, 9) < 4);
      r  = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 59) != 0);
      rp = 16'($urandom);
      cycle(s, r, rp, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
